mem_bus_arbiter: RTL

// Two-master arbiter for the native picorv32 memory bus (valid/ready/addr/wdata/wstrb/rdata).

---
 rtl/mem_bus_arbiter.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/mem_bus_arbiter.sv
// -----------------------------------------------------------------------------
// mem_bus_arbiter
//
// Two-master arbiter for the native picorv32 memory bus. Master 0 (CPU) and
// master 1 (boot loader / DMA) share one downstream memory + MMIO port.
// Round-robin on simultaneous requests. A downstream access that does not
// complete within TIMEOUT_CYC cycles is terminated with ERR_RDATA and a
// one-cycle bus_err pulse. All outputs are registered.
//
// Ports
//   clk, resetn                      clock, asynchronous active-low reset
//   m0_valid/addr/wdata/wstrb (in)   master 0 request, held until m0_ready
//   m0_ready/rdata (out)             master 0 completion pulse and read data
//   m1_*                             same set for master 1
//   mem_valid/addr/wdata/wstrb (out) downstream request
//   mem_ready/rdata (in)             downstream completion and read data
//   grant (out)                      owner of current/last transaction
//   bus_err (out)                    one-cycle pulse on timeout completion
// -----------------------------------------------------------------------------
module mem_bus_arbiter #(
    parameter int unsigned TIMEOUT_CYC = 64,
    parameter logic [31:0] ERR_RDATA   = 32'hDEAD_BEEF
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        m0_valid,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    input  logic [3:0]  m0_wstrb,
    output logic        m0_ready,
    output logic [31:0] m0_rdata,
    input  logic        m1_valid,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    input  logic [3:0]  m1_wstrb,
    output logic        m1_ready,
    output logic [31:0] m1_rdata,
    output logic        mem_valid,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,
    output logic        grant,
    output logic        bus_err
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_e;

    localparam int unsigned     CNT_W    = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    state_e            state_q, state_d;
    logic              mem_valid_q, mem_valid_d;
    logic [31:0]       mem_addr_q, mem_addr_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;
    logic [3:0]        mem_wstrb_q, mem_wstrb_d;
    logic              m0_ready_q, m0_ready_d;
    logic              m1_ready_q, m1_ready_d;
    logic [31:0]       m0_rdata_q, m0_rdata_d;
    logic [31:0]       m1_rdata_q, m1_rdata_d;
    logic              grant_q, grant_d;
    logic              last_grant_q, last_grant_d;
    logic              bus_err_q, bus_err_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic              req_any;
    logic              pick_m1;
    logic              timeout_hit;
    logic [31:0]       rsp_data;

    assign req_any     = m0_valid | m1_valid;
    // Master 1 wins when it is the only requester, or on a tie when master 0
    // owned the previous transaction.
    assign pick_m1     = m1_valid & (~m0_valid | ~last_grant_q);
    assign timeout_hit = (cnt_q == CNT_LAST);
    // A real completion in the timeout cycle takes precedence over the error.
    assign rsp_data    = mem_ready ? mem_rdata : ERR_RDATA;

    // State register
    // NOTE: sequential state is updated with non-blocking assignments so every
    // flop samples the pre-edge values, independent of process ordering.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        // NOTE: every variable assigned in a combinational block gets a default
        // first, so no path leaves it unassigned and no latch is inferred.
        state_d = state_q;
        case (state_q)
            IDLE:    if (req_any) state_d = ACCESS;
            ACCESS:  if (mem_ready || timeout_hit) state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output / datapath next-state logic
    always_comb begin
        mem_valid_d  = mem_valid_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        mem_wstrb_d  = mem_wstrb_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        cnt_d        = cnt_q;
        m0_ready_d   = 1'b0;
        m1_ready_d   = 1'b0;
        m0_rdata_d   = 32'd0;
        m1_rdata_d   = 32'd0;
        bus_err_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (req_any) begin
                    mem_valid_d  = 1'b1;
                    mem_addr_d   = pick_m1 ? m1_addr  : m0_addr;
                    mem_wdata_d  = pick_m1 ? m1_wdata : m0_wdata;
                    mem_wstrb_d  = pick_m1 ? m1_wstrb : m0_wstrb;
                    grant_d      = pick_m1;
                    last_grant_d = pick_m1;
                    cnt_d        = '0;
                end
            end
            ACCESS: begin
                if (mem_ready || timeout_hit) begin
                    mem_valid_d = 1'b0;
                    bus_err_d   = ~mem_ready;
                    if (grant_q) begin
                        m1_ready_d = 1'b1;
                        m1_rdata_d = rsp_data;
                    end else begin
                        m0_ready_d = 1'b1;
                        m0_rdata_d = rsp_data;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: ;  // RESP: pulses fall back to their zero defaults
        endcase
    end

    // Output / datapath registers
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            mem_valid_q  <= 1'b0;
            mem_addr_q   <= 32'd0;
            mem_wdata_q  <= 32'd0;
            mem_wstrb_q  <= 4'd0;
            m0_ready_q   <= 1'b0;
            m1_ready_q   <= 1'b0;
            m0_rdata_q   <= 32'd0;
            m1_rdata_q   <= 32'd0;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;   // master 0 wins the first tie
            bus_err_q    <= 1'b0;
            cnt_q        <= '0;
        end else begin
            mem_valid_q  <= mem_valid_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            mem_wstrb_q  <= mem_wstrb_d;
            m0_ready_q   <= m0_ready_d;
            m1_ready_q   <= m1_ready_d;
            m0_rdata_q   <= m0_rdata_d;
            m1_rdata_q   <= m1_rdata_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            bus_err_q    <= bus_err_d;
            cnt_q        <= cnt_d;
        end
    end

    assign mem_valid = mem_valid_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_wstrb = mem_wstrb_q;
    assign m0_ready  = m0_ready_q;
    assign m1_ready  = m1_ready_q;
    assign m0_rdata  = m0_rdata_q;
    assign m1_rdata  = m1_rdata_q;
    assign grant     = grant_q;
    assign bus_err   = bus_err_q;

endmodule
